// File: rtl/vec_mem_unit.sv
// Vector load/store sequencer: moves one LANES x LANE_W vector between the datapath
// and a word-wide data memory, one lane per accepted memory request.
module vec_mem_unit #(
  parameter int unsigned LANES  = 16,
  parameter int unsigned LANE_W = 16,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [3:0]                opcode,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [LANES*LANE_W-1:0]   st_data,
  output logic                      busy,
  output logic                      done,
  output logic [LANES*LANE_W-1:0]   ld_data,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_rd,
  output logic                      mem_wr,
  output logic [LANE_W-1:0]         mem_wdata,
  input  logic [LANE_W-1:0]         mem_rdata,
  input  logic                      mem_ready
);

  localparam int unsigned LANE_CW = $clog2(LANES);
  localparam logic [3:0]  OpVld   = 4'b0100;
  localparam logic [3:0]  OpVst   = 4'b0101;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e                    state_q, state_d;
  logic [LANE_CW-1:0]        lane_q, lane_d;
  logic                      is_vst_q, is_vst_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [LANES*LANE_W-1:0]   st_data_q, st_data_d;
  logic [LANES*LANE_W-1:0]   shadow_q, shadow_d;
  logic [LANES*LANE_W-1:0]   ld_data_q, ld_data_d;
  logic                      access;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      lane_q    <= '0;
      is_vst_q  <= 1'b0;
      addr_q    <= '0;
      st_data_q <= '0;
      shadow_q  <= '0;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      is_vst_q  <= is_vst_d;
      addr_q    <= addr_d;
      st_data_q <= st_data_d;
      shadow_q  <= shadow_d;
      ld_data_q <= ld_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    is_vst_d  = is_vst_q;
    addr_d    = addr_q;
    st_data_d = st_data_q;
    shadow_d  = shadow_q;
    ld_data_d = ld_data_q;
    unique case (state_q)
      StIdle: begin
        if (start && (opcode == OpVld || opcode == OpVst)) begin
          state_d  = StAccess;
          is_vst_d = (opcode == OpVst);
          addr_d   = addr;
          lane_d   = '0;
          if (opcode == OpVst) st_data_d = st_data;
        end
      end
      StAccess: begin
        if (mem_ready) begin
          if (!is_vst_q) begin
            for (int unsigned i = 0; i < LANES; i++) begin
              if (lane_q == LANE_CW'(i)) shadow_d[i*LANE_W +: LANE_W] = mem_rdata;
            end
          end
          lane_d = lane_q + LANE_CW'(1);
          if (lane_q == LANE_CW'(LANES - 1)) begin
            state_d = StDone;
            // Publish the whole vector at once, including the lane captured this cycle.
            if (!is_vst_q) ld_data_d = shadow_d;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign access   = (state_q == StAccess);
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign mem_rd   = access && !is_vst_q;
  assign mem_wr   = access && is_vst_q;
  assign mem_addr = access ? addr_q + ADDR_W'(lane_q) : '0;
  assign ld_data  = ld_data_q;

  always_comb begin
    mem_wdata = '0;
    if (mem_wr) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (lane_q == LANE_CW'(i)) mem_wdata = st_data_q[i*LANE_W +: LANE_W];
      end
    end
  end

endmodule

// File: tb/tb_vec_mem_unit.sv
// Randomized self-checking bench for vec_mem_unit against a word-array memory model.
module tb_vec_mem_unit;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   opcode;
  logic [15:0]  addr;
  logic [255:0] st_data;
  logic         busy, done, mem_rd, mem_wr, mem_ready;
  logic [255:0] ld_data;
  logic [15:0]  mem_addr, mem_wdata, mem_rdata;

  logic [15:0]  mem [0:65535];      // bus-side memory, written from observed DUT writes
  logic [15:0]  ref_mem [0:65535];  // reference memory, written from the intended stores
  logic [255:0] exp_ld;
  int           n_cmp = 0;
  int           n_bad = 0;

  vec_mem_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .opcode    (opcode),
    .addr      (addr),
    .st_data   (st_data),
    .busy      (busy),
    .done      (done),
    .ld_data   (ld_data),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic idle_checks(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_rdwr"}, {mem_rd, mem_wr}, 0);
      check({tag, "_ld"}, ld_data, exp_ld);
    end
  endtask

  // stall: 0 = ready always, 1 = ready low on the first cycle of each lane, 2 = random.
  // abort_lane >= 0 asserts reset while that lane is being requested.
  task automatic run_op(input logic [3:0] op, input logic [15:0] base, input logic [255:0] vec,
                        input int stall, input bit noise, input int abort_lane);
    logic         is_vld;
    logic [255:0] exp_vec;
    logic [15:0]  a;
    int           k, c;
    bit           rdy;
    is_vld  = (op == 4'b0100);
    exp_vec = '0;
    k       = 0;
    c       = 0;
    start   = 1'b1;
    opcode  = op;
    addr    = base;
    st_data = vec;
    while (k < 16 && c < 200) begin
      @(negedge clk);
      c++;
      a = base + 16'(k);
      check("acc_busy", busy, 1);
      check("acc_done", done, 0);
      check("acc_rd", mem_rd, is_vld);
      check("acc_wr", mem_wr, !is_vld);
      check("acc_addr", mem_addr, a);
      if (!is_vld) check("acc_wdata", mem_wdata, vec[16*k +: 16]);
      check("acc_ld_stable", ld_data, exp_ld);
      if (k == abort_lane) begin
        #2 rst_n = 1'b0;
        #1;
        exp_ld = '0;
        check("abort_busy", busy, 0);
        check("abort_rdwr", {mem_rd, mem_wr}, 0);
        check("abort_addr", mem_addr, 0);
        check("abort_ld", ld_data, 0);
        start = 1'b0;
        @(negedge clk);
        check("abort_done", done, 0);
        rst_n = 1'b1;
        return;
      end
      case (stall)
        0:       rdy = 1'b1;
        1:       rdy = (c % 2 == 0);
        default: rdy = ($urandom_range(0, 2) != 0);
      endcase
      mem_ready = rdy;
      if (rdy) begin
        if (is_vld) begin
          exp_vec[16*k +: 16] = ref_mem[a];
        end else begin
          if (mem_wr) mem[mem_addr] = mem_wdata;
          ref_mem[a] = vec[16*k +: 16];
        end
        k++;
      end
      start   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      opcode  = noise ? 4'($urandom_range(3, 6)) : op;
      addr    = noise ? 16'($urandom) : base;
      st_data = noise ? rand_vec() : vec;
    end
    start = 1'b0;
    if (k < 16) begin
      check("timeout", 0, 1);
      return;
    end
    @(negedge clk);
    c++;
    if (is_vld) exp_ld = exp_vec;
    check("done_pulse", done, 1);
    check("done_busy", busy, 1);
    check("done_rdwr", {mem_rd, mem_wr}, 0);
    check("done_ld", ld_data, exp_ld);
    if (stall == 0) check("latency_nostall", c, 17);
    if (stall == 1) check("latency_stall", c, 33);
    @(negedge clk);
    check("post_busy", busy, 0);
    check("post_done", done, 0);
    check("post_ld", ld_data, exp_ld);
    if (!is_vld) begin
      for (int i = 0; i < 16; i++) check("vst_mem", mem[base + 16'(i)], ref_mem[base + 16'(i)]);
    end
  endtask

  initial begin
    logic [255:0] v;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 16'h1000 + 16'(i);
      ref_mem[i] = 16'h1000 + 16'(i);
    end
    exp_ld = '0;
    rst_n  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start     = 1'($urandom_range(0, 1));
      opcode    = 4'($urandom_range(4, 5));
      addr      = 16'($urandom);
      st_data   = rand_vec();
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rdwr", {mem_rd, mem_wr}, 0);
      check("rst_addr_wdata", {mem_addr, mem_wdata}, 0);
      check("rst_ld", ld_data, 0);
    end
    start     = 1'b0;
    mem_ready = 1'b1;
    rst_n     = 1'b1;
    idle_checks("idle", 3);

    // Directed: VLD at 0x0020 without stalls.
    run_op(4'b0100, 16'h0020, '0, 0, 1'b0, -1);
    for (int i = 0; i < 16; i++) check("vld_lane", ld_data[16*i +: 16], 16'h1020 + 16'(i));

    // Directed: VST wrapping past 0xFFFF.
    for (int i = 0; i < 16; i++) v[16*i +: 16] = 16'hA000 + 16'(i);
    run_op(4'b0101, 16'hFFFE, v, 0, 1'b0, -1);
    check("wrap_mem_0000", mem[0], 16'hA002);
    check("wrap_mem_000d", mem[13], 16'hA00F);
    check("wrap_mem_000e", mem[14], 16'h100E);

    // Directed: VLD with alternating stalls, then read back the stored data.
    run_op(4'b0100, 16'hFFFE, '0, 1, 1'b0, -1);
    check("stall_lane0", ld_data[15:0], 16'hA000);

    // Ignored start with an invalid opcode.
    @(negedge clk);
    start  = 1'b1;
    opcode = 4'b0000;
    addr   = 16'h1234;
    @(negedge clk);
    start = 1'b0;
    check("bad_op_busy", busy, 0);
    idle_checks("bad_op", 3);

    // Starts during an active VLD must not disturb it.
    run_op(4'b0100, 16'h0100, '0, 0, 1'b1, -1);

    // Reset at lane 7, then a clean VLD.
    run_op(4'b0100, 16'h0300, '0, 0, 1'b0, 7);
    idle_checks("after_abort", 2);
    run_op(4'b0100, 16'h0300, '0, 0, 1'b0, -1);

    for (int n = 0; n < 24; n++) begin
      run_op(4'($urandom_range(4, 5)), 16'($urandom), rand_vec(), $urandom_range(0, 2),
             1'($urandom_range(0, 1)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vec_mem_unit.md
Name: vec_mem_unit

Overview:
- Memory stage directly downstream of the ALU.
- Consumes the 16-bit effective address the ALU produces for VLD/VST (ALU result[15:0]).
- Performs the 16 word-wide memory accesses that move one 256-bit vector between data memory and the vector datapath.
- Multi-cycle sequencer with a start/busy/done handshake toward the pipeline and a request/ready handshake toward a 16-bit data memory.

Parameters:
LANES, 16, number of 16-bit lanes per vector.
LANE_W, 16, lane width in bits; vector width = LANES*LANE_W = 256.
ADDR_W, 16, memory address width.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request pulse; sampled only in IDLE.
opcode  in  4  instruction code; 4'b0100 = VLD, 4'b0101 = VST.
addr  in  16  base word address (ALU result[15:0]).
st_data  in  256  vector to store; lane i = bits [16i+15:16i].
busy  out  1  high whenever state != IDLE.
done  out  1  one-cycle completion pulse.
ld_data  out  256  last completed VLD vector; lane i = bits [16i+15:16i].
mem_addr  out  16  memory word address.
mem_rd  out  1  read request.
mem_wr  out  1  write request.
mem_wdata  out  16  write data.
mem_rdata  in  16  read data; valid in any cycle where mem_rd && mem_ready.
mem_ready  in  1  memory completes the current request this cycle.

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE; lane counter = 0.
  - busy, done, mem_rd, mem_wr = 0.
  - mem_addr, mem_wdata = 0; ld_data = 0; internal shadow buffer = 0.
  - Reset mid-operation abandons the transfer with no done pulse; ld_data clears to 0.
- States: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - start=1 with opcode VLD or VST: latch opcode, addr and st_data (VST); clear lane counter; go to ACCESS.
  - start with any other opcode is ignored; the block stays in IDLE and issues no done.
- ACCESS:
  - Drive mem_addr = addr_latched + lane, modulo 2^16 (0xFFFF wraps to 0x0000).
  - VLD: mem_rd=1, mem_wr=0.
  - VST: mem_wr=1, mem_rd=0; mem_wdata = latched st_data lane [lane].
  - Hold the request stable until mem_ready=1.
  - On a mem_ready cycle:
    - VLD: capture mem_rdata into shadow lane [lane].
    - Increment lane.
    - After lane 15 completes, go to DONE; mem_rd and mem_wr deassert in DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - For VLD, ld_data <= shadow buffer on entry to DONE, so ld_data is valid in the done cycle.
  - ld_data is stable at all other times: it never shows partial vectors and is unchanged by VST.
- start while busy (ACCESS or DONE) is ignored; there is no queueing. Changes to addr, st_data or opcode during busy have no effect.
- Latency with mem_ready tied high, start accepted in cycle T:
  - ACCESS occupies T+1..T+16, one lane per cycle.
  - done is high in T+17; busy is high T+1..T+17.
  - A new start is accepted in T+18 at the earliest.
- Memory stalls: each mem_ready=0 cycle adds one cycle. The lane does not advance and the request stays asserted.
- Never both mem_rd and mem_wr in the same cycle.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> busy=done=mem_rd=mem_wr=0, ld_data=0; release -> IDLE, outputs unchanged until start.
- VLD, no stall: memory word k = 0x1000+k, mem_ready=1, start with opcode 0100, addr 0x0020 in cycle T -> mem_addr 0x0020..0x002F in T+1..T+16; done in T+17 only; ld_data lane i = 0x1020+i.
- VST with wrap: addr 0xFFFE, st_data lane i = 0xA000+i -> writes to 0xFFFE, 0xFFFF, 0x0000..0x000D with matching data; mem_rd never high; ld_data unchanged.
- Stalls: VLD with mem_ready low on every other cycle -> each request is held stable while ready is low; done in T+33; correct vector assembled; ld_data does not change before the done cycle.
- Ignored starts: start with opcode 0000 in IDLE -> no busy, no memory activity. Start pulses during an active VLD -> no effect on the address sequence or completion.
- Reset mid-transfer: assert rst_n=0 at lane 7 of a VLD -> immediate return to IDLE, requests drop asynchronously, no done, ld_data=0; a subsequent VLD completes normally.
